// File: rtl/elevator_pkg.sv
// elevator_pkg: shared sizes, FSM state encoding and floor-mask helpers for the elevator scheduler.
package elevator_pkg;
  localparam int NUM_FLOORS = 4;
  localparam int FLOOR_W = 2;
  localparam int CNT_W = 4;
  localparam int TRAVEL_DEF = 4;
  localparam int DOOR_DEF = 3;
  typedef enum logic [2:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, EMERG} state_t;
  typedef logic [NUM_FLOORS-1:0] fmask_t;
  function automatic fmask_t onehot(input logic [FLOOR_W-1:0] f);
    return fmask_t'(1) << f;
  endfunction
  function automatic fmask_t below(input logic [FLOOR_W-1:0] f);
    return onehot(f) - fmask_t'(1);
  endfunction
  function automatic fmask_t above(input logic [FLOOR_W-1:0] f);
    return ~(onehot(f) | below(f));
  endfunction
endpackage

// File: rtl/elev_cycle_timer.sv
// elev_cycle_timer: loadable down-counter; o_done flags the last cycle of a loaded interval.
module elev_cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_done
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end
  assign o_done = r_cnt == W'(1);
endmodule

// File: rtl/elevator_scheduler.sv
// elevator_scheduler: four-floor SCAN elevator controller with latched requests, door timing and emergency halt.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int TRAVEL_CYCLES = TRAVEL_DEF,
  parameter int DOOR_CYCLES = DOOR_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] floor_req,
  input  logic                  emergency_stop,
  output logic                  move_up,
  output logic                  move_down,
  output logic                  motor_stop,
  output logic                  door_open,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  direction,
  output logic [NUM_FLOORS-1:0] pending
);
  state_t r_state, w_next;
  logic [FLOOR_W-1:0] r_floor, w_floor_nxt, w_arr;
  logic [NUM_FLOORS-1:0] r_pend, w_clr;
  logic r_dir, w_dir_nxt, r_here, w_here_nxt;
  logic w_done, w_load, w_cont, w_up_any, w_dn_any;
  logic [CNT_W-1:0] w_tval;
  assign w_arr = (r_state == MOVE_UP) ? r_floor + 1'b1 : r_floor - 1'b1;
  assign w_cont = (r_state == MOVE_UP) ? |(r_pend & above(w_arr)) : |(r_pend & below(w_arr));
  assign w_up_any = |(r_pend & above(r_floor));
  assign w_dn_any = |(r_pend & below(r_floor));
  always_comb begin
    w_next = r_state;
    w_dir_nxt = r_dir;
    w_floor_nxt = r_floor;
    if (emergency_stop) w_next = EMERG;
    else
      case (r_state)
        IDLE:
          if (r_pend[r_floor] || r_here) w_next = DOOR_OPEN;
          else if (w_up_any && (r_dir || !w_dn_any)) begin
            w_next = MOVE_UP;
            w_dir_nxt = 1'b1;
          end else if (w_dn_any) begin
            w_next = MOVE_DOWN;
            w_dir_nxt = 1'b0;
          end
        MOVE_UP, MOVE_DOWN:
          if (w_done) begin
            w_floor_nxt = w_arr;
            w_next = r_pend[w_arr] ? DOOR_OPEN : w_cont ? r_state : IDLE;
          end
        DOOR_OPEN: w_next = w_done ? IDLE : DOOR_OPEN;
        default: w_next = IDLE;
      endcase
    // A request for the floor the car is parked or open at is absorbed rather than latched
    w_clr = (!emergency_stop && (w_next == DOOR_OPEN || r_state == DOOR_OPEN ||
             (r_state == IDLE && w_next == IDLE))) ? onehot(w_floor_nxt) : '0;
    w_here_nxt = (r_state == IDLE && !emergency_stop) ? (w_next == IDLE && floor_req[r_floor]) : r_here;
    w_load = (w_next == DOOR_OPEN || w_next == MOVE_UP || w_next == MOVE_DOWN) && (w_next != r_state || w_done);
    w_tval = (w_next == DOOR_OPEN) ? CNT_W'(DOOR_CYCLES) : CNT_W'(TRAVEL_CYCLES);
  end
  elev_cycle_timer #(.W(CNT_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .i_load(w_load),
    .i_val (w_tval),
    .o_done(w_done)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_floor <= '0;
      r_dir <= 1'b1;
      r_pend <= '0;
      r_here <= 1'b0;
    end else begin
      r_state <= w_next;
      r_floor <= w_floor_nxt;
      r_dir <= w_dir_nxt;
      r_pend <= (r_pend | floor_req) & ~w_clr;
      r_here <= w_here_nxt;
    end
  end
  assign move_up = r_state == MOVE_UP;
  assign move_down = r_state == MOVE_DOWN;
  assign door_open = r_state == DOOR_OPEN;
  assign motor_stop = !(move_up || move_down);
  assign current_floor = r_floor;
  assign direction = r_dir;
  assign pending = r_pend;
endmodule

// File: doc/elevator_scheduler.md
ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

Interface
REQ-001 Parameter TRAVEL_CYCLES, default 4, clock cycles to travel one floor (legal range 1..15).
REQ-002 Parameter DOOR_CYCLES, default 3, clock cycles the door is held open (legal range 1..15).
REQ-003 clk  in  1  single system clock, all flops on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 floor_req  in  4  one bit per floor 0..3, level or single-cycle pulse, latched on any edge where high.
REQ-006 emergency_stop  in  1  level, halts the car while high.
REQ-007 move_up / move_down / motor_stop  out  1 each  registered motor commands, exactly one high every cycle.
REQ-008 door_open  out  1  registered, high while the door is held open.
REQ-009 current_floor  out  2  registered car position, 0..3.
REQ-010 direction  out  1  scan direction, 1=up, 0=down.
REQ-011 pending  out  4  latched unserved requests.

Function
REQ-012 The FSM SHALL have states IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, EMERG; all outputs are Moore outputs of registered state.
REQ-013 pending SHALL update each edge as (pending | floor_req) & ~clear, where clear is the one-hot of the floor being serviced that edge; service clear wins over a same-edge set.
REQ-014 IDLE: if pending[current_floor], go to DOOR_OPEN and clear that bit; else if any pending bit lies in the current direction, move that way; else if any lies opposite, flip direction and move; else stay.
REQ-015 Request held at edge k from IDLE SHALL appear in pending after edge k and move_up/move_down or door_open SHALL assert after edge k+1.
REQ-016 MOVE_*: travel counter SHALL count TRAVEL_CYCLES cycles; at terminal count current_floor steps +/-1 and the counter reloads.
REQ-017 On arrival: pending at new floor -> DOOR_OPEN (bit cleared); else further pending in same direction -> continue; else -> IDLE.
REQ-018 The car SHALL never command up at floor 3 or down at floor 0; current_floor SHALL NOT wrap.
REQ-019 DOOR_OPEN SHALL last exactly DOOR_CYCLES cycles, then IDLE; requests for current_floor during DOOR_OPEN are absorbed (never set in pending) without restarting the timer.
REQ-020 emergency_stop high at any edge SHALL enter EMERG: motor_stop=1, door_open=0, partial travel discarded, current_floor held, pending retained and still accepting requests.
REQ-021 emergency_stop low in EMERG SHALL return to IDLE next edge; resumed travel takes a full TRAVEL_CYCLES.
REQ-022 motor_stop SHALL be 1 in IDLE, DOOR_OPEN and EMERG.

Reset
REQ-023 rst SHALL force on the next edge: state IDLE, current_floor 0, direction 1, pending 0, counters 0, motor_stop 1, move_up/move_down/door_open 0.
REQ-024 rst SHALL dominate emergency_stop and floor_req; reset mid-travel discards position (floor returns to 0).

Structure
REQ-025 Package elevator_pkg SHALL hold NUM_FLOORS=4, FLOOR_W=2, the state enumeration and default TRAVEL/DOOR cycle constants.
REQ-026 One sub-module elev_cycle_timer (loadable down-counter with done flag) SHALL be shared by travel and door timing, as these are mutually exclusive.

Verification (TRAVEL_CYCLES=4, DOOR_CYCLES=3)
REQ-027 After reset, floor_req=0100 one cycle -> move_up 8 cycles, floor 1 then 2, door_open 3 cycles, pending 0000, IDLE.
REQ-028 Car at floor 2 direction up, floor_req=1010 -> serves floor 3 first, then reverses, serves 1; direction toggles to 0.
REQ-029 IDLE at floor 1, floor_req=0010 -> door_open 3 cycles, no move_up/move_down, pending bit never set.
REQ-030 emergency_stop high 3 cycles mid-travel 1->2 -> motor_stop next edge, floor stays 1, pending kept; after release 4 cycles to floor 2.
REQ-031 rst during MOVE_DOWN with pending 0001 -> next edge all REQ-023 values, pending 0000.
REQ-032 From floor 0, floor_req=1110 -> stops at 1, 2, 3 in order, each with 3-cycle door_open; exactly-one-motor-output checked every cycle.
